bcd_bin_converter: RTL and testbench
====================================

// Module: bcd_bin_converter
// PURPOSE
//  Parametrised, bidirectional, iterative BCD<->binary converter for the calculator datapath.
//  Converts DIGITS packed BCD digits to binary (reverse double-dabble) or binary to BCD (double-dabble).
//  Processes one bit per clock and uses a start/done handshake.
//  Sits between keypad/display BCD registers and the binary ALU.
// PARAMETERS
//  DIGITS   4   number of BCD digits; legal range 1..9
//  BIN_W    localparam = $clog2(10**DIGITS); binary width (14 for DIGITS=4)
// PORTS
//  clk       in   1          system clock, rising edge
//  reset     in   1          asynchronous reset, active-low
//  start     in   1          request; sampled in IDLE only
//  mode      in   1          0 = BCD->binary, 1 = binary->BCD; sampled with start
//  data_in   in   4*DIGITS   operand; binary uses bits [BIN_W-1:0], upper bits must be 0
//  data_out  out  4*DIGITS   result; binary result is zero-extended
//  busy      out  1          high from the cycle after start is accepted until done
//  done      out  1          one-cycle completion pulse
//  err       out  1          invalid operand; valid while done=1, held until next accept
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; data_out, busy, done, err all 0.
//   Reset mid-conversion aborts the operation; no done pulse is produced.
//  FSM: IDLE -> CHECK -> SHIFT (BIN_W cycles, down-counter) -> DONE -> IDLE.
//  IDLE: start=1 captures data_in and mode into working registers at the edge; next state CHECK.
//  CHECK: validates the operand.
//   On error: next state DONE with err=1 and data_out=0.
//   Otherwise: next state SHIFT with err=0.
//  SHIFT, mode 0: shift {bcd,bin} right by 1, then subtract 3 from every BCD digit >= 8.
//  SHIFT, mode 1: add 3 to every BCD digit >= 5, then shift {bcd,bin} left by 1.
//  DONE: data_out registered, done=1 for exactly one cycle, busy=0; next state IDLE.
//  Latency, start sampled at edge k:
//   done is high in the cycle after edge k+BIN_W+1 (16 cycles for DIGITS=4).
//   On error, done is high after edge k+1.
//  Throughput: with start held high, a new accept every BIN_W+3 cycles.
//  start during CHECK, SHIFT or DONE is ignored (not queued).
//   Changes on mode or data_in after accept are ignored.
//  data_out holds the last result between operations; it changes only in DONE.
//  Boundaries:
//   All-zero input gives a zero result.
//   Max BCD input (all 9s) gives 10**DIGITS-1.
//   Binary input >= 10**DIGITS sets err.
//  Arithmetic is on unsigned values only; no sign handling.
// CONFIGURATION
//  BCD_BIN_CHECK_EN defined: CHECK performs validation.
//   Mode 0: any nibble > 9 sets err.
//   Mode 1: value >= 10**DIGITS, or any nonzero bit above BIN_W-1, sets err.
//  BCD_BIN_CHECK_EN undefined: CHECK always proceeds to SHIFT and err is tied to 0.
//   Invalid operands produce unspecified data_out; latency is always BIN_W+2.
// STRUCTURE
//  Package bcd_bin_pkg:
//   state encoding (IDLE, CHECK, SHIFT, DONE)
//   MODE_BCD2BIN=1'b0, MODE_BIN2BCD=1'b1
//   digit correction constants: 3, adjust thresholds 5 and 8
//  Sub-module bcd_digit_adj: combinational per-nibble +3/-3 corrector selected by mode.
//   Instantiated DIGITS times in a generate loop.
//  Top level holds the FSM, iteration counter, combined shift register and output registers.
// TESTING (DIGITS=4, BCD_BIN_CHECK_EN defined unless noted)
//  1. mode=0, data_in=16'h1234 -> data_out=16'h04D2, err=0, done 16 cycles after accept; busy high throughout.
//  2. mode=1, data_in=16'h162E -> 16'h5678.
//     mode=0, 16'h9999 -> 16'h270F; mode=1, 16'h270F -> 16'h9999.
//     mode=0, 16'h0000 -> 16'h0000.
//  3. mode=0, 16'h12A4 -> err=1, data_out=0, done 2 cycles after accept.
//     mode=1, 16'h2710 -> err=1.
//     Rebuild without the macro: same 16'h12A4 stimulus -> err=0, latency 16.
//  4. Extra start pulses and mode/data_in changes during SHIFT -> ignored.
//     Result of the original operation is unchanged; exactly one done pulse.
//  5. reset=0 asserted mid-SHIFT -> busy, done, err and data_out 0 immediately.
//     After release, a fresh 16'h0042 mode-0 conversion -> 16'h002A.
//  6. start held high for 3 operations -> done pulses spaced 17 cycles apart.
//     data_out is stable between pulses.

Source files
------------

// File: rtl/bcd_bin_pkg.sv
// Shared definitions for the iterative BCD<->binary converter.
// Optional operand validation is enabled by defining BCD_BIN_CHECK_EN.
package bcd_bin_pkg;

  // Width of one packed BCD digit
  localparam int unsigned NIBBLE_W = 4;

  // Converter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Conversion direction, sampled together with start
  localparam logic MODE_BCD2BIN = 1'b0;
  localparam logic MODE_BIN2BCD = 1'b1;

  // Per-digit correction amount and the thresholds that trigger it
  localparam logic [NIBBLE_W-1:0] ADJ_CONST  = 4'd3;
  localparam logic [NIBBLE_W-1:0] ADD_THRESH = 4'd5;
  localparam logic [NIBBLE_W-1:0] SUB_THRESH = 4'd8;

  // Largest legal decimal digit value
  localparam logic [NIBBLE_W-1:0] DIGIT_MAX  = 4'd9;

endpackage : bcd_bin_pkg

// File: rtl/bcd_digit_adj.sv
// Combinational single-digit corrector for (reverse) double-dabble.
// Binary->BCD adds 3 to digits >= 5 before the left shift;
// BCD->binary subtracts 3 from digits >= 8 after the right shift.
module bcd_digit_adj
  import bcd_bin_pkg::*;
(
  input  logic                mode,
  input  logic [NIBBLE_W-1:0] digit,
  output logic [NIBBLE_W-1:0] adj_c
);

  // Select the correction for the active conversion direction
  always_comb begin
    adj_c = digit;
    if (mode == MODE_BIN2BCD) begin
      if (digit >= ADD_THRESH) begin
        adj_c = digit + ADJ_CONST;
      end
    end else begin
      if (digit >= SUB_THRESH) begin
        adj_c = digit - ADJ_CONST;
      end
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bcd_bin_converter.sv
// Bidirectional iterative BCD<->binary converter, one bit per clock.
// Mode 0 runs reverse double-dabble (BCD->binary), mode 1 runs double-dabble
// (binary->BCD) on a single combined {bcd, bin} shift register.
// Define BCD_BIN_CHECK_EN to validate operands in the CHECK state; without it
// CHECK always proceeds to SHIFT and err stays 0.
// DIGITS is legal over 1..9.
module bcd_bin_converter
  import bcd_bin_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
  output logic [NIBBLE_W*DIGITS-1:0]   data_out,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned DW    = NIBBLE_W * DIGITS;
  localparam int unsigned BIN_W = $clog2(10 ** DIGITS);
  localparam int unsigned SW    = DW + BIN_W;
  localparam int unsigned CW    = $clog2(BIN_W + 1);

  // Control state
  state_t state_q;
  state_t state_d;

  // Working registers captured on accept
  logic          mode_q;
  logic [DW-1:0] op_q;

  // Combined {bcd, bin} shift register and iteration down-counter
  logic [SW-1:0] sr_q;
  logic [CW-1:0] cnt_q;

  // Next values of the registered outputs
  logic [DW-1:0] data_out_d;
  logic          busy_d;
  logic          done_d;
  logic          err_d;

  // Datapath intermediates
  logic          chk_err_c;
  logic [SW-1:0] sr_rs_c;
  logic [DW-1:0] adj_in_c;
  logic [DW-1:0] adj_out_c;
  logic [SW-1:0] sr_step_c;
  logic [SW-1:0] sr_load_c;
  logic [DW-1:0] result_c;
  logic          accept_c;
  logic          last_shift_c;

  assign accept_c     = (state_q == ST_IDLE) && start;
  assign last_shift_c = (state_q == ST_SHIFT) && (cnt_q == '0);

`ifdef BCD_BIN_CHECK_EN
  localparam int unsigned LIMIT = 10 ** DIGITS;

  // Flag non-decimal nibbles (mode 0) or out-of-range binary values (mode 1)
  always_comb begin
    chk_err_c = 1'b0;
    if (mode_q == MODE_BCD2BIN) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (op_q[NIBBLE_W*i +: NIBBLE_W] > DIGIT_MAX) begin
          chk_err_c = 1'b1;
        end
      end
    end else begin
      // Any bit above BIN_W-1 also makes the value exceed LIMIT
      chk_err_c = (op_q >= DW'(LIMIT));
    end
  end
`else
  assign chk_err_c = 1'b0;
`endif

  // Right-shifted copy used by the BCD->binary step
  assign sr_rs_c = {1'b0, sr_q[SW-1:1]};

  // Binary->BCD corrects before shifting, BCD->binary after
  assign adj_in_c = (mode_q == MODE_BIN2BCD) ? sr_q[SW-1:BIN_W] : sr_rs_c[SW-1:BIN_W];

  // One corrector per BCD digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .mode  (mode_q),
      .digit (adj_in_c[NIBBLE_W*g +: NIBBLE_W]),
      .adj_c (adj_out_c[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  // One iteration of the selected algorithm
  always_comb begin
    if (mode_q == MODE_BIN2BCD) begin
      sr_step_c = {adj_out_c[DW-2:0], sr_q[BIN_W-1:0], 1'b0};
    end else begin
      sr_step_c = {adj_out_c, sr_rs_c[BIN_W-1:0]};
    end
  end

  // Initial shift register contents for the captured operand
  always_comb begin
    if (mode_q == MODE_BIN2BCD) begin
      sr_load_c = {DW'(0), op_q[BIN_W-1:0]};
    end else begin
      sr_load_c = {op_q, BIN_W'(0)};
    end
  end

  // Final result after the last iteration, binary zero-extended
  always_comb begin
    if (mode_q == MODE_BIN2BCD) begin
      result_c = sr_step_c[SW-1:BIN_W];
    end else begin
      result_c = DW'(sr_step_c[BIN_W-1:0]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = chk_err_c ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    data_out_d = data_out;
    err_d      = err;
    busy_d     = (state_d == ST_CHECK) || (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
    if (accept_c) begin
      err_d = 1'b0;
    end
    if ((state_q == ST_CHECK) && chk_err_c) begin
      err_d      = 1'b1;
      data_out_d = '0;
    end
    if (last_shift_c) begin
      data_out_d = result_c;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      data_out <= data_out_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Working registers, shift register and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_BCD2BIN;
      op_q   <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept_c) begin
        mode_q <= mode;
        op_q   <= data_in;
      end
      if (state_q == ST_CHECK) begin
        sr_q  <= sr_load_c;
        cnt_q <= CW'(BIN_W - 1);
      end else if (state_q == ST_SHIFT) begin
        sr_q  <= sr_step_c;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule : bcd_bin_converter

// File: tb/tb_bcd_bin_converter.sv
// Self-checking bench for bcd_bin_converter with DIGITS=4.
// Expectations follow BCD_BIN_CHECK_EN when it is defined for the build.
module tb_bcd_bin_converter;

  localparam int unsigned DIGITS  = 4;
  localparam int          LAT_OK  = 16;
  localparam int          LAT_ERR = 2;
  localparam int          SPACING = 17;
`ifdef BCD_BIN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_bin_converter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic        m;
    logic [15:0] din;
    logic [15:0] dout;
    logic        bad;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal arithmetic on the operand, no shifting involved
  function automatic void model(input logic m, input logic [15:0] d,
                                output logic [15:0] q, output logic bad);
    int unsigned v;
    logic [15:0] t;
    q   = '0;
    bad = 1'b0;
    t   = d;
    if (m == 1'b0) begin
      v = 0;
      for (int i = 3; i >= 0; i--) begin
        if (t[4*i +: 4] > 4'd9) bad = 1'b1;
        v = v * 10 + 32'(t[4*i +: 4]);
      end
      q = 16'(v);
    end else begin
      v = 32'(d);
      if (v >= 10000) begin
        bad = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          q[4*i +: 4] = 4'(v % 10);
          v = v / 10;
        end
      end
    end
  endfunction

  // One conversion; lat counts cycles from the one after the accept edge
  task automatic run_op(input logic m, input logic [15:0] d,
                        output logic [15:0] q, output logic e,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    mode = m; data_in = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mode = ~m; data_in = 16'($urandom);
    lat = 1; busy_ok = 1'b1; q = '0; e = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done) begin
      q = data_out; e = err;
      if (busy) busy_ok = 1'b0;
    end else begin
      lat = -1;
    end
    @(negedge clk);
  endtask

  // Apply one operation and compare everything against the expectation
  task automatic apply_and_check(input string name, input logic m, input logic [15:0] d,
                                 input logic [15:0] exp_q, input logic bad);
    logic [15:0] q;
    logic        e;
    int          lat;
    logic        bok;
    logic        exp_err;
    exp_err = CHECK_EN & bad;
    run_op(m, d, q, e, lat, bok);
    chk({name, "_err"}, 32'(e), 32'(exp_err));
    chk({name, "_lat"}, 32'(lat), 32'(exp_err ? LAT_ERR : LAT_OK));
    chk({name, "_busy"}, 32'(bok), 32'd1);
    if (!bad || exp_err) begin
      chk({name, "_dout"}, 32'(q), 32'(exp_err ? 16'h0000 : exp_q));
      chk({name, "_hold"}, 32'(data_out), 32'(exp_err ? 16'h0000 : exp_q));
    end
    chk({name, "_errhold"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] q;
    logic        m;
    logic        bad;
    int          dones;
    logic [15:0] seen;
    int          dcyc;

    vecs[0]  = '{1'b0, 16'h1234, 16'h04D2, 1'b0, "b2b_1234"};
    vecs[1]  = '{1'b1, 16'h162E, 16'h5678, 1'b0, "b2d_162e"};
    vecs[2]  = '{1'b0, 16'h9999, 16'h270F, 1'b0, "b2b_9999"};
    vecs[3]  = '{1'b1, 16'h270F, 16'h9999, 1'b0, "b2d_270f"};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, "b2b_zero"};
    vecs[5]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, "b2d_zero"};
    vecs[6]  = '{1'b0, 16'h12A4, 16'h0000, 1'b1, "b2b_12a4"};
    vecs[7]  = '{1'b1, 16'h2710, 16'h0000, 1'b1, "b2d_2710"};
    vecs[8]  = '{1'b0, 16'h0042, 16'h002A, 1'b0, "b2b_0042"};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, "b2d_ffff"};
    vecs[10] = '{1'b1, 16'h0001, 16'h0001, 1'b0, "b2d_one"};

    reset = 1'b0; start = 1'b0; mode = 1'b0; data_in = '0;
    #1;
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      apply_and_check(vecs[i].name, vecs[i].m, vecs[i].din, vecs[i].dout, vecs[i].bad);
    end

    // Randomized operands against the decimal reference
    for (int i = 0; i < 50; i++) begin
      m = 1'($urandom_range(0, 1));
      if (m == 1'b0) begin
        for (int k = 0; k < 4; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) d[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      end else begin
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(10000, 65535))
                                         : 16'($urandom_range(0, 9999));
      end
      model(m, d, q, bad);
      apply_and_check("rand", m, d, q, bad);
    end

    // Extra starts and input changes during a conversion are ignored
    @(negedge clk);
    mode = 1'b0; data_in = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; seen = '0; dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dones++; seen = data_out;
        if (dcyc == 0) dcyc = c;
      end
      if (c >= 3 && c <= 10) begin
        start = 1'b1; mode = 1'($urandom); data_in = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_dout", 32'(seen), 32'h04D2);
    chk("ign_lat", 32'(dcyc), 32'(LAT_OK));

    // Start held high: back-to-back accepts, output stable between pulses
    begin
      int pulses[$];
      int unstable;
      int c;
      logic [15:0] held;
      unstable = 0; c = 0; held = '0;
      @(negedge clk);
      mode = 1'b0; data_in = 16'h0042; start = 1'b1;
      while (pulses.size() < 3 && c < 100) begin
        @(negedge clk);
        c++;
        if (done) begin
          pulses.push_back(c);
          chk("b2b_dout", 32'(data_out), 32'h002A);
          held = data_out;
          if (pulses.size() == 3) start = 1'b0;
        end else if (pulses.size() > 0 && data_out !== held) begin
          unstable++;
        end
      end
      start = 1'b0;
      chk("b2b_pulses", 32'(pulses.size()), 32'd3);
      if (pulses.size() == 3) begin
        chk("b2b_gap1", 32'(pulses[1] - pulses[0]), 32'(SPACING));
        chk("b2b_gap2", 32'(pulses[2] - pulses[1]), 32'(SPACING));
      end
      chk("b2b_stable", 32'(unstable), 32'd0);
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset in the middle of SHIFT
    mode = 1'b0; data_in = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_dout", 32'(data_out), 32'h002A);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err",  32'(err),  32'd0);
    chk("arst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_nodone", 32'(dones), 32'd0);
    apply_and_check("post_rst", 1'b0, 16'h0042, 16'h002A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bcd_bin_converter
